// File: rtl/fire_pkg.sv
// Shared constants and operand types for the fire expand convolution layers.
// Pixels and weights are signed fixed point, 2 integer / FRAC_BITS fractional bits.
package fire_pkg;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned ACC_WIDTH = 2 * WIDTH;
    localparam int unsigned FRAC_BITS = 14;

    typedef logic signed [WIDTH-1:0]     pix_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/mac_core_if.sv
// Operand and result bundle between a fire layer and one mac_core lane.
// The layer drives operands and controls (master); the lane consumes them (slave).
interface mac_core_if #(
    parameter int unsigned WIDTH     = fire_pkg::WIDTH,
    parameter int unsigned ACC_WIDTH = fire_pkg::ACC_WIDTH
);

    logic                        clr;
    logic                        layer_en;
    logic signed [WIDTH-1:0]     pix;
    logic signed [WIDTH-1:0]     ker;
    logic signed [ACC_WIDTH-1:0] mul_out;

    modport master (
        output clr,
        output layer_en,
        output pix,
        output ker,
        input  mul_out
    );

    modport slave (
        input  clr,
        input  layer_en,
        input  pix,
        input  ker,
        output mul_out
    );

endinterface

// File: rtl/mac_core.sv
// Single signed multiply-accumulate lane: one pix*ker product per cycle into a
// double-width wrapping accumulator; clr restarts the sum without a bubble.
module mac_core
    import fire_pkg::*;
#(
    parameter int unsigned WIDTH     = fire_pkg::WIDTH,
    parameter int unsigned ACC_WIDTH = fire_pkg::ACC_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    mac_core_if.slave  mac
);

    logic signed [WIDTH-1:0]     pix_w;
    logic signed [WIDTH-1:0]     ker_w;
    logic signed [ACC_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_q;

    assign pix_w = mac.pix;
    assign ker_w = mac.ker;

    // Sign-extend before multiplying so the full double-width product is kept.
    assign prod = ACC_WIDTH'(pix_w) * ACC_WIDTH'(ker_w);

    // Operands are only selected when layer_en is high, so X operands on idle
    // cycles never reach the register.
    always_comb begin
        acc_d = acc_q;
        if (mac.clr) begin
            acc_d = mac.layer_en ? prod : '0;
        end else if (mac.layer_en) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign mac.mul_out = acc_q;

endmodule

// File: tb/tb_mac_core.sv
// Directed self-checking bench for mac_core with hand-computed expected sums.
module tb_mac_core;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mac_core_if #(.WIDTH(16), .ACC_WIDTH(32)) bus ();

    mac_core #(
        .WIDTH     (16),
        .ACC_WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mac (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic c, input logic e, input logic [15:0] p,
                         input logic [15:0] k);
        bus.clr      = c;
        bus.layer_en = e;
        bus.pix      = p;
        bus.ker      = k;
    endtask

    // Apply inputs at the falling edge, clock once, sample at the next falling edge.
    task automatic step(input logic c, input logic e, input logic [15:0] p,
                        input logic [15:0] k);
        drive(c, e, p, k);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] exp);
        checks++;
        assert (bus.mul_out === exp)
        else begin
            failures++;
            $error("FAIL %s: mul_out=%h expected=%h", tag, bus.mul_out, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        chk("reset_value", 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 16'h1111, 16'h2222);
        chk("idle_after_reset", 32'h0000_0000);

        // Asynchronous reset in the middle of a cycle discards the partial sum.
        step(1'b1, 1'b1, 16'h1234, 16'h0001);
        chk("load_1234", 32'h0000_1234);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_mid_cycle", 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_release", 32'h0000_0000);
        step(1'b0, 1'b0, 16'h1234, 16'h0001);
        chk("stays_zero_until_en", 32'h0000_0000);

        // 16 x (1.0 * 0.5) wraps to the sign bit.
        step(1'b1, 1'b1, 16'h4000, 16'h2000);
        chk("dot_first_term", 32'h0800_0000);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 16'h4000, 16'h2000);
        chk("dot_16_terms_wrap", 32'h8000_0000);

        step(1'b1, 1'b1, 16'h4000, 16'h0400);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 16'h4000, 16'h0400);
        chk("dot_ker_0400", 32'h1000_0000);

        step(1'b1, 1'b1, 16'hFFFF, 16'h0003);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hFFFF, 16'h0003);
        chk("signed_neg12", 32'hFFFF_FFF4);

        // Restart: mul_out shows the old sum throughout the clr cycle.
        step(1'b1, 1'b1, 16'd10, 16'd10);
        chk("sum_100", 32'd100);
        drive(1'b1, 1'b1, 16'd2, 16'd5);
        #1;
        chk("during_clr_old_sum", 32'd100);
        @(posedge clk);
        @(negedge clk);
        chk("restart_10", 32'd10);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
        end
        step(1'b0, 1'b0, 16'hxxxx, 16'hxxxx);
        chk("hold_5_cycles", 32'd10);
        step(1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
        chk("clr_without_en", 32'h0000_0000);

        // 0x40000000 + 0x3FFF0001 + 0xFFFE = 0x7FFFFFFF, then +1 wraps.
        step(1'b1, 1'b1, 16'h8000, 16'h8000);
        chk("min_times_min", 32'h4000_0000);
        step(1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
        step(1'b0, 1'b1, 16'h7FFF, 16'h0002);
        chk("reach_max", 32'h7FFF_FFFF);
        step(1'b0, 1'b1, 16'h0001, 16'h0001);
        chk("wrap_to_min", 32'h8000_0000);

        // rst and clr together: rst wins.
        drive(1'b1, 1'b1, 16'h0100, 16'h0100);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_beats_clr", 32'h0000_0000);
        rst = 1'b0;
        step(1'b1, 1'b1, 16'hFFFE, 16'h0003);
        chk("after_rst_clr_load", 32'hFFFF_FFFA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
